// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for serial_frame_rx: FSM state encoding, counter width and the
// hex-to-7-segment decoder.
package serial_frame_pkg;

    // Wide enough for the largest supported length field (4 bits).
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StSearch,
        StLen,
        StData,
        StPar
    } state_e;

    // Active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_ssd(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/pb_sync_pulse.sv
// Two-flop synchroniser for an asynchronous board input. With EDGE_DETECT set the output is a
// one-clk pulse per rising edge of the synchronised level, otherwise the synchronised level.
module pb_sync_pulse #(
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    if (EDGE_DETECT) begin : g_edge
        logic prev_q, prev_d;

        always_comb begin
            prev_d = sync_q[1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= prev_d;
            end
        end

        assign q_o = sync_q[1] & ~prev_q;
    end else begin : g_level
        assign q_o = sync_q[1];
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Push-button-clocked framed serial receiver: start pattern, length field, payload forwarding,
// remaining-count 7-segment display. Define PARITY_EN for a trailing even-parity bit + frame_err.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned          PATTERN_W      = 4,
    parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1011,
    parameter int unsigned          LEN_W          = 4,
    parameter bit                   SSD_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkPB,
    input  logic       SerIn,
    output logic       SerOutValid,
    output logic       SerOut,
`ifdef PARITY_EN
    output logic       frame_err,
`endif
    output logic [6:0] SSD
);

    function automatic logic [6:0] drive_seg(input logic [3:0] v);
        return SSD_ACTIVE_LOW ? ~hex_to_ssd(v) : hex_to_ssd(v);
    endfunction

    logic smp, ser;

    pb_sync_pulse #(.EDGE_DETECT(1'b1)) u_pb_sync (
        .clk (clk),
        .rst (rst),
        .d_i (clkPB),
        .q_o (smp)
    );

    pb_sync_pulse #(.EDGE_DETECT(1'b0)) u_ser_sync (
        .clk (clk),
        .rst (rst),
        .d_i (SerIn),
        .q_o (ser)
    );

    state_e               state_q, state_d;
    // Only the previous PATTERN_W-1 bits are kept; the incoming bit completes the window.
    logic [PATTERN_W-2:0] pat_q, pat_d;
    logic [CNT_W-2:0]     len_q, len_d;
    logic [CNT_W-1:0]     bit_q, bit_d, rem_q, rem_d;
    logic                 valid_q, valid_d, out_q, out_d;
    logic [6:0]           ssd_q, ssd_d;
`ifdef PARITY_EN
    logic                 par_q, par_d, err_q, err_d;
`endif

    logic [PATTERN_W-1:0] window;
    logic [CNT_W-1:0]     len_shift;
    logic [3:0]           disp;
    logic                 search_step;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        bit_d       = bit_q;
        rem_d       = rem_q;
        valid_d     = valid_q;
        out_d       = out_q;
        ssd_d       = ssd_q;
`ifdef PARITY_EN
        par_d       = par_q;
        err_d       = err_q;
`endif
        window      = {pat_q, ser};
        len_shift   = {len_q, ser};
        disp        = 4'd0;
        search_step = 1'b0;

        if (smp) begin
            valid_d = 1'b0;
            out_d   = 1'b0;
            unique case (state_q)
                StSearch: search_step = 1'b1;
                StLen: begin
                    len_d = len_shift[CNT_W-2:0];
                    bit_d = bit_q + CNT_W'(1);
                    if (bit_q == CNT_W'(LEN_W - 1)) begin
                        len_d = '0;
                        bit_d = '0;
                        if (len_shift == '0) begin
`ifdef PARITY_EN
                            state_d = StPar;
`else
                            state_d = StSearch;
`endif
                        end else begin
                            rem_d   = len_shift;
                            disp    = len_shift;
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (rem_q != '0) begin
                        valid_d = 1'b1;
                        out_d   = ser;
                        rem_d   = rem_q - CNT_W'(1);
                        // Display counts the bit being presented as still remaining.
                        disp    = rem_q;
`ifdef PARITY_EN
                        par_d   = par_q ^ ser;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = StPar;
                        end
`endif
                    end else begin
                        // Frame complete: this bit already belongs to the next search.
                        search_step = 1'b1;
                    end
                end
                StPar: begin
`ifdef PARITY_EN
                    err_d = par_q ^ ser;
                    par_d = 1'b0;
`endif
                    state_d = StSearch;
                end
                default: state_d = StSearch;
            endcase

            if (search_step) begin
                state_d = StSearch;
                pat_d   = window[PATTERN_W-2:0];
                if (window == PATTERN) begin
                    state_d = StLen;
                    pat_d   = '0;
                    bit_d   = '0;
                    len_d   = '0;
`ifdef PARITY_EN
                    par_d   = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end
            ssd_d = drive_seg(disp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSearch;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= 1'b0;
            ssd_q   <= drive_seg(4'd0);
`ifdef PARITY_EN
            par_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            ssd_q   <= ssd_d;
`ifdef PARITY_EN
            par_q   <= par_d;
            err_q   <= err_d;
`endif
        end
    end

    assign SerOutValid = valid_q;
    assign SerOut      = out_q;
    assign SSD         = ssd_q;
`ifdef PARITY_EN
    assign frame_err   = err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (default parameters, active-low segments). Runs the
// parity scenarios instead of the plain-frame ones when PARITY_EN is defined.
module tb_serial_frame_rx;

    localparam int S0 = 'h40;
    localparam int S1 = 'h79;
    localparam int S2 = 'h24;
    localparam int S3 = 'h30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clkPB = 1'b0;
    logic       SerIn = 1'b0;
    logic       SerOutValid;
    logic       SerOut;
    logic [6:0] SSD;
`ifdef PARITY_EN
    logic       frame_err;
`endif

    int total = 0;
    int bad = 0;

    serial_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .clkPB       (clkPB),
        .SerIn       (SerIn),
        .SerOutValid (SerOutValid),
        .SerOut      (SerOut),
`ifdef PARITY_EN
        .frame_err   (frame_err),
`endif
        .SSD         (SSD)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int v, input int o, input int s);
        check_eq({tag, ".valid"}, int'(SerOutValid), v);
        check_eq({tag, ".out"}, int'(SerOut), o);
        check_eq({tag, ".ssd"}, int'(SSD), s);
    endtask

    // Inputs change on the falling edge; the sample is consumed on the third rising edge.
    task automatic press(input logic b, input int hi, input int lo);
        @(negedge clk);
        SerIn = b;
        clkPB = 1'b1;
        repeat (hi) @(negedge clk);
        clkPB = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send(input logic b);
        press(b, 3, 2);
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_out("reset", 0, 0, S0);
`ifdef PARITY_EN
        check_eq("reset.err", int'(frame_err), 0);
`endif
        rst = 1'b0;

`ifdef PARITY_EN
        send_seq(16'b1011_0010, 8);
        send(1'b1);
        check_out("p1.d0", 1, 1, S2);
        send(1'b1);
        check_out("p1.d1", 1, 1, S1);
        send(1'b0);
        check_eq("p1.par.valid", int'(SerOutValid), 0);
        check_eq("p1.par.err", int'(frame_err), 0);

        send_seq(16'b1011_0010, 8);
        send(1'b1);
        send(1'b1);
        send(1'b1);
        check_eq("p2.par.valid", int'(SerOutValid), 0);
        check_eq("p2.par.err", int'(frame_err), 1);
        send_seq(16'b101, 3);
        check_eq("p2.hold.err", int'(frame_err), 1);
        send(1'b1);
        check_eq("p2.clear.err", int'(frame_err), 0);
`else
        // Basic frame, length 3.
        send_seq(16'b1011_0011, 8);
        check_out("t1.len", 0, 0, S3);
        send(1'b1);
        check_out("t1.d0", 1, 1, S3);
        send(1'b0);
        check_out("t1.d1", 1, 0, S2);
        send(1'b1);
        check_out("t1.d2", 1, 1, S1);
        send(1'b0);
        check_out("t1.end", 0, 0, S0);

        // Overlapping detection, length 1.
        send_seq(16'b10_1011, 6);
        send_seq(16'b0001, 4);
        check_out("t2.len", 0, 0, S1);
        send(1'b0);
        check_out("t2.d0", 1, 0, S1);
        send(1'b0);
        check_out("t2.end", 0, 0, S0);

        // Zero length, then an immediate new frame of length 2.
        send_seq(16'b1011_0000, 8);
        check_out("t3.len0", 0, 0, S0);
        send_seq(16'b1011_0010, 8);
        check_out("t3.len", 0, 0, S2);
        send(1'b1);
        check_out("t3.d0", 1, 1, S2);
        send(1'b1);
        check_out("t3.d1", 1, 1, S1);
        send(1'b0);
        check_out("t3.end", 0, 0, S0);

        // Long button hold on the last length bit gives a single sample.
        send_seq(16'b1011_000, 7);
        press(1'b1, 20, 2);
        check_out("t4.hold", 0, 0, S1);
        send(1'b0);
        check_out("t4.d0", 1, 0, S1);
        send(1'b0);
        check_out("t4.end", 0, 0, S0);

        // One sample per 4 clk.
        for (int i = 7; i >= 0; i--) begin
            press(((8'b1011_0010 >> i) & 8'd1) != 8'd0, 2, 1);
        end
        check_out("t5.len", 0, 0, S2);
        press(1'b1, 2, 1);
        check_out("t5.d0", 1, 1, S2);
        press(1'b0, 2, 1);
        check_out("t5.d1", 1, 0, S1);
        press(1'b0, 2, 1);
        check_out("t5.end", 0, 0, S0);

        // Reset in the middle of a payload.
        send_seq(16'b1011_0011, 8);
        send(1'b1);
        check_out("t6.d0", 1, 1, S3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_out("t6.rst", 0, 0, S0);
        rst = 1'b0;
        send(1'b1);
        check_out("t6.noresume", 0, 0, S0);
        send_seq(16'b011, 3);
        send_seq(16'b0001, 4);
        check_out("t6.len", 0, 0, S1);
        send(1'b1);
        check_out("t6.d0b", 1, 1, S1);
        send(1'b0);
        check_out("t6.end", 0, 0, S0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
